// File: rtl/alu_exec_unit.sv
// ALU control + execute unit: decodes aluOp/fun3/fun7, latches operands on start, returns a registered result.
// Optional iterative M-extension mul/div is enabled by defining RV_MULDIV_EN.
module alu_exec_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [1:0]      aluOp,
    input  logic [2:0]      fun3,
    input  logic [6:0]      fun7,
    input  logic [XLEN-1:0] opA,
    input  logic [XLEN-1:0] opB,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic            zero,
    output logic            illegal,
    output logic [1:0]      state_dbg
);
    localparam int SW = $clog2(XLEN);
    localparam int CW = SW + 1;

    // Handshake: start is taken only in the cycle busy==0; busy stays high until the
    // cycle after the single-cycle done pulse, so the next start can follow done directly.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_DONE = 2'd2
`ifdef RV_MULDIV_EN
        , S_ITER = 2'd3
`endif
    } state_e;

    typedef enum logic [3:0] {
        OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_SRL, OP_SRA, OP_OR, OP_AND
    } op_e;

    state_e          state, state_n;
    op_e             dec_op, op_q;
    logic            dec_ill, ill_q, accept;
    logic [XLEN-1:0] a_q, b_q, alu_out;
    logic [SW-1:0]   shamt;

    assign accept    = (state == S_IDLE) && start;
    assign state_dbg = state;
    assign shamt     = b_q[SW-1:0];

    always_comb begin
        dec_op  = OP_ADD;
        dec_ill = 1'b0;
        case (aluOp)
            2'b00: dec_op = OP_ADD;
            2'b01: dec_op = OP_SUB;
            default: begin
                case (fun3)
                    3'b000:  dec_op = (aluOp == 2'b10 && fun7 == 7'h20) ? OP_SUB : OP_ADD;
                    3'b001:  dec_op = OP_SLL;
                    3'b010:  dec_op = OP_SLT;
                    3'b011:  dec_op = OP_SLTU;
                    3'b100:  dec_op = OP_XOR;
                    3'b101:  dec_op = (fun7 == 7'h20) ? OP_SRA : OP_SRL;
                    3'b110:  dec_op = OP_OR;
                    default: dec_op = OP_AND;
                endcase
                if (aluOp == 2'b10)
                    dec_ill = !((fun7 == 7'h00) ||
                                (fun7 == 7'h20 && (fun3 == 3'b000 || fun3 == 3'b101)));
                else
                    dec_ill = (fun3 == 3'b001 && fun7 != 7'h00) ||
                              (fun3 == 3'b101 && fun7 != 7'h00 && fun7 != 7'h20);
            end
        endcase
`ifdef RV_MULDIV_EN
        if (aluOp == 2'b10 && fun7 == 7'h01) dec_ill = 1'b0;
`endif
    end

    always_comb begin
        alu_out = '0;
        case (op_q)
            OP_ADD:  alu_out = a_q + b_q;
            OP_SUB:  alu_out = a_q - b_q;
            OP_SLL:  alu_out = a_q << shamt;
            OP_SLT:  alu_out = {{(XLEN-1){1'b0}}, $signed(a_q) < $signed(b_q)};
            OP_SLTU: alu_out = {{(XLEN-1){1'b0}}, a_q < b_q};
            OP_XOR:  alu_out = a_q ^ b_q;
            OP_SRL:  alu_out = a_q >> shamt;
            OP_SRA:  alu_out = $unsigned($signed(a_q) >>> shamt);
            OP_OR:   alu_out = a_q | b_q;
            default: alu_out = a_q & b_q;
        endcase
    end

`ifdef RV_MULDIV_EN
    // Shared shift registers: mul keeps {partial, multiplier}, div keeps {remainder, quotient}.
    logic            dec_md, is_div, sgn_a, sgn_b, neg_q, neg_r;
    logic [2:0]      md_f3_q;
    logic [XLEN-1:0] hi, lo, mop, mag_a, mag_b, md_res;
    logic [XLEN:0]   mul_sum, div_sh, div_diff;
    logic [2*XLEN-1:0] prod_s;
    logic [CW-1:0]   cnt;

    assign dec_md   = (aluOp == 2'b10) && (fun7 == 7'h01);
    assign is_div   = fun3[2];
    assign sgn_a    = opA[XLEN-1] & (is_div ? !fun3[0] : (fun3 == 3'b001 || fun3 == 3'b010));
    assign sgn_b    = opB[XLEN-1] & (is_div ? !fun3[0] : (fun3 == 3'b001));
    assign mag_a    = sgn_a ? -opA : opA;
    assign mag_b    = sgn_b ? -opB : opB;
    assign mul_sum  = {1'b0, hi} + (lo[0] ? {1'b0, mop} : '0);
    assign div_sh   = {hi, lo[XLEN-1]};
    assign div_diff = div_sh - {1'b0, mop};
    assign prod_s   = neg_q ? -{hi, lo} : {hi, lo};

    always_comb begin
        md_res = '0;
        case (md_f3_q)
            3'b000:         md_res = prod_s[XLEN-1:0];
            3'b001, 3'b010,
            3'b011:         md_res = prod_s[2*XLEN-1:XLEN];
            3'b100, 3'b101: md_res = (b_q == '0) ? '1 : (neg_q ? -lo : lo);
            default:        md_res = (b_q == '0) ? a_q : (neg_r ? -hi : hi);
        endcase
    end
`endif

    always_comb begin
        state_n = state;
        busy    = (state != S_IDLE);
        done    = (state == S_DONE);
        case (state)
            S_IDLE: if (start) begin
`ifdef RV_MULDIV_EN
                state_n = dec_md ? S_ITER : S_EXEC;
`else
                state_n = S_EXEC;
`endif
            end
            S_EXEC: state_n = S_DONE;
`ifdef RV_MULDIV_EN
            // XLEN step cycles plus one sign/special-case cycle give the XLEN+2 latency.
            S_ITER: if (cnt == CW'(XLEN)) state_n = S_DONE;
`endif
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_n;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= OP_ADD;
            ill_q   <= 1'b0;
            result  <= '0;
            zero    <= 1'b1;
            illegal <= 1'b0;
`ifdef RV_MULDIV_EN
            md_f3_q <= '0;
            hi      <= '0;
            lo      <= '0;
            mop     <= '0;
            neg_q   <= 1'b0;
            neg_r   <= 1'b0;
            cnt     <= '0;
`endif
        end else begin
            if (accept) begin
                a_q   <= opA;
                b_q   <= opB;
                op_q  <= dec_op;
                ill_q <= dec_ill;
`ifdef RV_MULDIV_EN
                md_f3_q <= fun3;
                hi      <= '0;
                lo      <= is_div ? mag_a : mag_b;
                mop     <= is_div ? mag_b : mag_a;
                neg_q   <= sgn_a ^ sgn_b;
                neg_r   <= sgn_a;
                cnt     <= '0;
`endif
            end
            if (state == S_EXEC) begin
                result  <= ill_q ? '0 : alu_out;
                zero    <= ill_q || (alu_out == '0);
                illegal <= ill_q;
            end
`ifdef RV_MULDIV_EN
            if (state == S_ITER) begin
                if (cnt != CW'(XLEN)) begin
                    cnt <= cnt + CW'(1);
                    if (!md_f3_q[2]) begin
                        hi <= mul_sum[XLEN:1];
                        lo <= {mul_sum[0], lo[XLEN-1:1]};
                    end else if (!div_diff[XLEN]) begin
                        hi <= div_diff[XLEN-1:0];
                        lo <= {lo[XLEN-2:0], 1'b1};
                    end else begin
                        hi <= div_sh[XLEN-1:0];
                        lo <= {lo[XLEN-2:0], 1'b0};
                    end
                end else begin
                    result  <= md_res;
                    zero    <= (md_res == '0);
                    illegal <= 1'b0;
                end
            end
`endif
        end
    end
endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed self-checking bench for alu_exec_unit (XLEN=32); mul/div vectors follow RV_MULDIV_EN.
module tb_alu_exec_unit;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  aluOp = '0;
    logic [2:0]  fun3 = '0;
    logic [6:0]  fun7 = '0;
    logic [31:0] opA = '0;
    logic [31:0] opB = '0;
    logic        busy, done, zero, illegal;
    logic [31:0] result;
    logic [1:0]  state_dbg;

    int n_vec = 0;
    int n_miss = 0;
    logic [31:0] exp_q[$];

`ifdef RV_MULDIV_EN
    localparam int MD_LAT = 34;
`else
    localparam int MD_LAT = 2;
`endif

    alu_exec_unit #(.XLEN(32)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .aluOp(aluOp), .fun3(fun3), .fun7(fun7),
        .opA(opA), .opB(opB), .busy(busy), .done(done), .result(result), .zero(zero),
        .illegal(illegal), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // One operation: operands are scrambled right after acceptance to show they were latched.
    task automatic run_op(input string tag, input logic [1:0] op, input logic [2:0] f3,
                          input logic [6:0] f7, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] er, input logic ez, input logic ei, input int elat);
        int lat;
        logic [31:0] exp;
        exp_q.push_back(er);
        @(negedge clk);
        aluOp = op; fun3 = f3; fun7 = f7; opA = a; opB = b; start = 1'b1;
        @(posedge clk);
        lat = 1;
        #1;
        start = 1'b0;
        opA = $urandom; opB = $urandom;
        fun3 = 3'($urandom_range(0, 7)); fun7 = 7'($urandom_range(0, 127));
        aluOp = 2'($urandom_range(0, 3));
        @(negedge clk);
        while (!done && lat < 100) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        exp = exp_q.pop_front();
        check({tag, ".result"}, result, exp);
        check({tag, ".zero"}, {31'b0, zero}, {31'b0, ez});
        check({tag, ".illegal"}, {31'b0, illegal}, {31'b0, ei});
        check({tag, ".latency"}, 32'(lat), 32'(elat));
        @(posedge clk);
        #1;
        check({tag, ".done_pulse"}, {31'b0, done}, 32'd0);
        check({tag, ".busy_after"}, {31'b0, busy}, 32'd0);
    endtask

    initial begin
        #12;
        check("rst.busy", {31'b0, busy}, 32'd0);
        check("rst.done", {31'b0, done}, 32'd0);
        check("rst.result", result, 32'd0);
        check("rst.zero", {31'b0, zero}, 32'd1);
        check("rst.illegal", {31'b0, illegal}, 32'd0);
        check("rst.state", {30'b0, state_dbg}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op("r_sub",   2'b10, 3'b000, 7'h20, 32'd5, 32'd7, 32'hFFFFFFFE, 1'b0, 1'b0, 2);
        run_op("i_sra",   2'b11, 3'b101, 7'h20, 32'h80000000, 32'd4, 32'hF8000000, 1'b0, 1'b0, 2);
        run_op("i_srl",   2'b11, 3'b101, 7'h00, 32'h80000000, 32'd4, 32'h08000000, 1'b0, 1'b0, 2);
        run_op("i_slt",   2'b11, 3'b010, 7'h7F, 32'hFFFFFFFF, 32'd1, 32'd1, 1'b0, 1'b0, 2);
        run_op("i_sltu",  2'b11, 3'b011, 7'h00, 32'hFFFFFFFF, 32'd1, 32'd0, 1'b1, 1'b0, 2);
        run_op("ld_add",  2'b00, 3'b111, 7'h7F, 32'd3, 32'd4, 32'd7, 1'b0, 1'b0, 2);
        run_op("br_sub",  2'b01, 3'b100, 7'h00, 32'd9, 32'd9, 32'd0, 1'b1, 1'b0, 2);
        run_op("r_xor",   2'b10, 3'b100, 7'h00, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 1'b0, 1'b0, 2);
        run_op("r_or",    2'b10, 3'b110, 7'h00, 32'hF0F0F0F0, 32'h0F0F0000, 32'hFFFFF0F0, 1'b0, 1'b0, 2);
        run_op("r_and",   2'b10, 3'b111, 7'h00, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b0, 1'b0, 2);
        run_op("r_sll",   2'b10, 3'b001, 7'h00, 32'd1, 32'd33, 32'd2, 1'b0, 1'b0, 2);
        run_op("r_sltu",  2'b10, 3'b011, 7'h00, 32'd1, 32'hFFFFFFFF, 32'd1, 1'b0, 1'b0, 2);
        run_op("r_srl",   2'b10, 3'b101, 7'h00, 32'h80000000, 32'd31, 32'd1, 1'b0, 1'b0, 2);
        run_op("i_addw",  2'b11, 3'b000, 7'h7F, 32'd10, 32'hFFFFFFFF, 32'd9, 1'b0, 1'b0, 2);
        run_op("i_sll_b", 2'b11, 3'b001, 7'h20, 32'd1, 32'd1, 32'd0, 1'b1, 1'b1, 2);
        run_op("i_sra_b", 2'b11, 3'b101, 7'h7F, 32'd1, 32'd1, 32'd0, 1'b1, 1'b1, 2);
        run_op("r_slt_b", 2'b10, 3'b010, 7'h20, 32'd1, 32'd2, 32'd0, 1'b1, 1'b1, 2);
        run_op("r_f7_7f", 2'b10, 3'b000, 7'h7F, 32'd5, 32'd7, 32'd0, 1'b1, 1'b1, 2);

`ifdef RV_MULDIV_EN
        run_op("div_ovf", 2'b10, 3'b100, 7'h01, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b0, 1'b0, MD_LAT);
        run_op("divu_0",  2'b10, 3'b101, 7'h01, 32'd7, 32'd0, 32'hFFFFFFFF, 1'b0, 1'b0, MD_LAT);
        run_op("rem_0",   2'b10, 3'b110, 7'h01, 32'd7, 32'd0, 32'd7, 1'b0, 1'b0, MD_LAT);
        run_op("mulhu",   2'b10, 3'b011, 7'h01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0, 1'b0, MD_LAT);
        run_op("mul",     2'b10, 3'b000, 7'h01, 32'd6, 32'hFFFFFFF9, 32'hFFFFFFD6, 1'b0, 1'b0, MD_LAT);
        run_op("mulh_1",  2'b10, 3'b001, 7'h01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 1'b1, 1'b0, MD_LAT);
        run_op("mulh_n",  2'b10, 3'b001, 7'h01, 32'h80000000, 32'd2, 32'hFFFFFFFF, 1'b0, 1'b0, MD_LAT);
        run_op("mulhsu",  2'b10, 3'b010, 7'h01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0, MD_LAT);
        run_op("div_neg", 2'b10, 3'b100, 7'h01, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 1'b0, 1'b0, MD_LAT);
        run_op("rem_neg", 2'b10, 3'b110, 7'h01, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 1'b0, 1'b0, MD_LAT);
        run_op("remu",    2'b10, 3'b111, 7'h01, 32'd100, 32'd7, 32'd2, 1'b0, 1'b0, MD_LAT);
`else
        run_op("mul_off", 2'b10, 3'b000, 7'h01, 32'd6, 32'd7, 32'd0, 1'b1, 1'b1, MD_LAT);
`endif

        // start held high: accepts on cycles 0,3,6 with done on 2,5,8
        @(negedge clk);
        aluOp = 2'b00; fun3 = 3'b000; fun7 = 7'h00; opA = 32'd10; opB = 32'd20; start = 1'b1;
        for (int k = 0; k < 9; k++) begin
            check($sformatf("hold.busy%0d", k), {31'b0, busy}, {31'b0, (k % 3) != 0});
            check($sformatf("hold.done%0d", k), {31'b0, done}, {31'b0, (k % 3) == 2});
            if (done) check($sformatf("hold.result%0d", k), result, 32'd30);
            @(negedge clk);
        end
        start = 1'b0;
        @(posedge clk);
        #1;
        check("hold.idle", {31'b0, busy}, 32'd0);

        // asynchronous reset in the middle of an operation
        @(negedge clk);
        aluOp = 2'b10; fun3 = 3'b000; opA = 32'd6; opB = 32'd7; start = 1'b1;
`ifdef RV_MULDIV_EN
        fun7 = 7'h01;
`else
        fun7 = 7'h00;
`endif
        @(posedge clk);
        #1;
        start = 1'b0;
`ifdef RV_MULDIV_EN
        repeat (5) @(posedge clk);
        #1;
`endif
        #2;
        rst_n = 1'b0;
        #1;
        check("arst.busy", {31'b0, busy}, 32'd0);
        check("arst.done", {31'b0, done}, 32'd0);
        check("arst.result", result, 32'd0);
        check("arst.zero", {31'b0, zero}, 32'd1);
        check("arst.state", {30'b0, state_dbg}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op("post_rst", 2'b10, 3'b000, 7'h00, 32'h7FFFFFFF, 32'd1, 32'h80000000, 1'b0, 1'b0, 2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
